// File: rtl/step_prompt_judge.sv
// Round sequencer and hit judge for the two-player dance game.
// Produces a pseudo-random one-hot arrow per step on a SHOW/GAP schedule.
// Judges each player's first press in the window at the start of SHOW.
module step_prompt_judge #(
   parameter int unsigned STEP_TICKS   = 25_000_000,
   parameter int unsigned WINDOW_TICKS = 12_500_000,
   parameter int unsigned GAP_TICKS    = 5_000_000,
   parameter int unsigned NUM_STEPS    = 32,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] a_btn,
   input  logic [3:0] b_btn,
   output logic [3:0] arrow,
   output logic       busy,
   output logic       done,
   output logic [7:0] step_idx,
   output logic       a_hit,
   output logic       b_hit,
   output logic       a_miss,
   output logic       b_miss,
   output logic [7:0] a_score,
   output logic [7:0] b_score
);

   localparam int unsigned TMAX = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [15:0]   lfsr;
   logic [3:0]    a_prev;
   logic [3:0]    b_prev;
   logic          a_judged;
   logic          b_judged;

   logic [15:0]   lfsr_next;
   logic [3:0]    arrow_next;
   logic          in_window;
   logic          show_end;
   logic          gap_end;
   logic          last_step;
   logic          a_judge;
   logic          b_judge;
   logic          a_good;
   logic          b_good;

   // Step timing, press-edge qualification and next prompt
   always_comb begin
      lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
      arrow_next = 4'(4'b0001 << lfsr_next[1:0]);
      in_window  = (state == SHOW) && (32'(timer) < WINDOW_TICKS);
      show_end   = (state == SHOW) && (timer == TW'(STEP_TICKS - 1));
      gap_end    = (state == GAP)  && (timer == TW'(GAP_TICKS - 1));
      last_step  = (step_idx == 8'(NUM_STEPS - 1));
      a_judge    = in_window && ((a_btn & ~a_prev) != 4'd0) && !a_judged;
      b_judge    = in_window && ((b_btn & ~b_prev) != 4'd0) && !b_judged;
      a_good     = (a_btn == arrow);
      b_good     = (b_btn == arrow);
   end

   // Round FSM with registered prompt, judgement pulses and scores
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         lfsr     <= LFSR_SEED;
         a_prev   <= 4'd0;
         b_prev   <= 4'd0;
         a_judged <= 1'b0;
         b_judged <= 1'b0;
         arrow    <= 4'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         step_idx <= 8'd0;
         a_hit    <= 1'b0;
         b_hit    <= 1'b0;
         a_miss   <= 1'b0;
         b_miss   <= 1'b0;
         a_score  <= 8'd0;
         b_score  <= 8'd0;
      end else begin
         a_prev <= a_btn;
         b_prev <= b_btn;
         a_hit  <= 1'b0;
         b_hit  <= 1'b0;
         a_miss <= 1'b0;
         b_miss <= 1'b0;

         // Player A: a press judgement wins over the timeout miss
         if (a_judge) begin
            a_judged <= 1'b1;
            if (a_good) begin
               a_hit <= 1'b1;
               if (a_score != 8'hFF) a_score <= a_score + 8'd1;
            end else begin
               a_miss <= 1'b1;
            end
         end else if (show_end && !a_judged) begin
            a_miss <= 1'b1;
         end

         // Player B: same rules, fully independent of A
         if (b_judge) begin
            b_judged <= 1'b1;
            if (b_good) begin
               b_hit <= 1'b1;
               if (b_score != 8'hFF) b_score <= b_score + 8'd1;
            end else begin
               b_miss <= 1'b1;
            end
         end else if (show_end && !b_judged) begin
            b_miss <= 1'b1;
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_score  <= 8'd0;
                  b_score  <= 8'd0;
                  step_idx <= 8'd0;
                  lfsr     <= lfsr_next;
                  arrow    <= arrow_next;
                  timer    <= '0;
                  a_judged <= 1'b0;
                  b_judged <= 1'b0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  state    <= SHOW;
               end
            end
            SHOW: begin
               if (show_end) begin
                  arrow <= 4'd0;
                  timer <= '0;
                  state <= GAP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            GAP: begin
               if (gap_end) begin
                  timer <= '0;
                  if (last_step) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     step_idx <= step_idx + 8'd1;
                     lfsr     <= lfsr_next;
                     arrow    <= arrow_next;
                     a_judged <= 1'b0;
                     b_judged <= 1'b0;
                     state    <= SHOW;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_step_prompt_judge.sv
// Bench for step_prompt_judge: round-level reference model checked every
// cycle, directed scenarios with literal expectations, random play, and a
// long-round instance that drives a score into saturation.
module tb_step_prompt_judge;

   localparam int ST = 8;
   localparam int WI = 4;
   localparam int GP = 2;
   localparam int NS = 3;
   localparam int PER = ST + GP;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a_btn = 4'd0;
   logic [3:0] b_btn = 4'd0;
   logic [3:0] arrow;
   logic       busy, done;
   logic [7:0] step_idx;
   logic       a_hit, b_hit, a_miss, b_miss;
   logic [7:0] a_score, b_score;

   // second instance: long round used to reach score saturation
   logic       start2 = 1'b0;
   logic [3:0] a2_btn = 4'd0;
   logic [3:0] b2_btn = 4'd0;
   logic [3:0] arrow2;
   logic       busy2, done2;
   logic [7:0] step2;
   logic       a2_hit, b2_hit, a2_miss, b2_miss;
   logic [7:0] a2_score, b2_score;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_on   = 1'b0;

   always #5 clock = ~clock;

   step_prompt_judge #(
      .STEP_TICKS(ST), .WINDOW_TICKS(WI), .GAP_TICKS(GP), .NUM_STEPS(NS), .LFSR_SEED(16'hACE1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .a_btn(a_btn), .b_btn(b_btn),
      .arrow(arrow), .busy(busy), .done(done), .step_idx(step_idx),
      .a_hit(a_hit), .b_hit(b_hit), .a_miss(a_miss), .b_miss(b_miss),
      .a_score(a_score), .b_score(b_score)
   );

   step_prompt_judge #(
      .STEP_TICKS(3), .WINDOW_TICKS(2), .GAP_TICKS(1), .NUM_STEPS(256), .LFSR_SEED(16'hACE1)
   ) dut_sat (
      .clock(clock), .reset(reset), .start(start2), .a_btn(a2_btn), .b_btn(b2_btn),
      .arrow(arrow2), .busy(busy2), .done(done2), .step_idx(step2),
      .a_hit(a2_hit), .b_hit(b2_hit), .a_miss(a2_miss), .b_miss(b2_miss),
      .a_score(a2_score), .b_score(b2_score)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // ---------------- reference model (round-relative cycle count) ----------
   logic [15:0] m_lfsr = 16'hACE1;
   bit          m_active = 1'b0;
   int          m_cnt = 0;
   logic [3:0]  m_prev [2];
   bit          m_judged [2];
   logic [3:0]  m_btn [2];
   int          m_pos;
   logic [3:0]  e_arrow = 4'd0;
   bit          e_busy = 1'b0;
   bit          e_done = 1'b0;
   int          e_step = 0;
   bit          e_hit [2];
   bit          e_miss [2];
   int          e_score [2];

   always @(posedge clock) begin
      m_btn[0] = a_btn;
      m_btn[1] = b_btn;
      for (int p = 0; p < 2; p++) begin
         e_hit[p]  = 1'b0;
         e_miss[p] = 1'b0;
      end
      if (reset) begin
         m_lfsr = 16'hACE1;
         m_active = 1'b0;
         m_cnt = 0;
         e_arrow = 4'd0;
         e_busy = 1'b0;
         e_done = 1'b0;
         e_step = 0;
         for (int p = 0; p < 2; p++) begin
            e_score[p] = 0;
            m_judged[p] = 1'b0;
         end
      end else if (m_active) begin
         m_pos = m_cnt % PER;
         for (int p = 0; p < 2; p++) begin
            if (m_pos < WI && !m_judged[p] && ((m_btn[p] & ~m_prev[p]) != 4'd0)) begin
               m_judged[p] = 1'b1;
               if (m_btn[p] == e_arrow) begin
                  e_hit[p] = 1'b1;
                  if (e_score[p] < 255) e_score[p]++;
               end else begin
                  e_miss[p] = 1'b1;
               end
            end
            if (m_pos == ST - 1 && !m_judged[p]) begin
               e_miss[p] = 1'b1;
               m_judged[p] = 1'b1;
            end
         end
         m_cnt++;
         if (m_cnt == NS * PER) begin
            m_active = 1'b0;
            e_done = 1'b1;
            e_busy = 1'b0;
            e_arrow = 4'd0;
         end else begin
            m_pos = m_cnt % PER;
            e_step = m_cnt / PER;
            if (m_pos == 0) begin
               m_lfsr = lfsr_adv(m_lfsr);
               e_arrow = 4'b0001 << m_lfsr[1:0];
               m_judged[0] = 1'b0;
               m_judged[1] = 1'b0;
            end else if (m_pos == ST) begin
               e_arrow = 4'd0;
            end
         end
      end else if (start) begin
         for (int p = 0; p < 2; p++) begin
            e_score[p] = 0;
            m_judged[p] = 1'b0;
         end
         m_lfsr = lfsr_adv(m_lfsr);
         e_arrow = 4'b0001 << m_lfsr[1:0];
         e_step = 0;
         e_busy = 1'b1;
         e_done = 1'b0;
         m_cnt = 0;
         m_active = 1'b1;
      end
      if (reset) begin
         m_prev[0] = 4'd0;
         m_prev[1] = 4'd0;
      end else begin
         m_prev[0] = m_btn[0];
         m_prev[1] = m_btn[1];
      end
   end

   // Every-cycle comparison of the DUT against the model
   always @(negedge clock) begin
      if (chk_on) begin
         chk("arrow", arrow, e_arrow);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("step_idx", step_idx, e_step);
         chk("a_hit", a_hit, e_hit[0]);
         chk("b_hit", b_hit, e_hit[1]);
         chk("a_miss", a_miss, e_miss[0]);
         chk("b_miss", b_miss, e_miss[1]);
         chk("a_score", a_score, e_score[0]);
         chk("b_score", b_score, e_score[1]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   int hits2, amiss2, bhits2, bmiss2, r;
   bit fin2;

   initial begin
      // reset state
      tick(3);
      chk("rst_arrow", arrow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_scores", {a_score, b_score}, 0);
      reset = 1'b0;
      chk_on = 1'b1;
      tick(2);

      // round 1: first prompt from advanced seed is 4'b0001
      start = 1'b1; tick(1); start = 1'b0;
      chk("first_arrow", arrow, 4'b0001);
      chk("first_busy", busy, 1);
      chk("first_step", step_idx, 0);
      tick(1); b_btn = 4'b0011;                       // chord at timer 1
      tick(1); chk("b_chord_miss", b_miss, 1);
      chk("b_score_hold", b_score, 0);
      a_btn = 4'b0001;                                  // exact arrow at timer 2
      tick(1); chk("a_hit", a_hit, 1);
      chk("a_score1", a_score, 1);
      tick(2); a_btn = 4'd0;
      tick(1); a_btn = 4'b0001;                         // second press, ignored
      tick(1); chk("a_second_press", a_hit, 0);
      tick(1); chk("no_timeout_a", a_miss, 0);
      chk("no_timeout_b", b_miss, 0);
      chk("gap_arrow", arrow, 0);
      a_btn = 4'd0;
      tick(2); chk("step1_idx", step_idx, 1);          // b held across boundary
      tick(5); a_btn = 4'b0001;                         // window closed
      tick(1); chk("late_press", {a_hit, a_miss}, 0);
      tick(2); chk("timeout_a", a_miss, 1);
      chk("timeout_b_held", b_miss, 1);
      a_btn = 4'd0; b_btn = 4'd0;
      tick(3); a_btn = 4'b0001; b_btn = 4'b0100;       // simultaneous at timer 1
      tick(1); chk("sim_a_hit", a_hit, 1);
      chk("sim_b_miss", b_miss, 1);
      chk("a_score2", a_score, 2);
      a_btn = 4'd0; b_btn = 4'd0;
      tick(8);
      chk("done", done, 1);
      chk("done_arrow", arrow, 0);
      chk("done_busy", busy, 0);
      chk("done_step", step_idx, 2);

      // round 2 continues the LFSR, then reset mid-SHOW
      start = 1'b1; tick(1); start = 1'b0;
      chk("round2_arrow", arrow, 4'b0100);
      chk("round2_score", a_score, 0);
      tick(3); reset = 1'b1;
      tick(1);
      chk("midrst_outs", {arrow, busy, done, step_idx, a_hit, b_hit, a_miss, b_miss, a_score, b_score}, 0);
      reset = 1'b0;
      start = 1'b1; tick(1); start = 1'b0;
      chk("reseed_arrow", arrow, 4'b0001);
      tick(35);

      // random play, including starts while busy and occasional reset
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom % 40) == 0;
         reset = ($urandom % 600) == 0;
         if (($urandom % 3) == 0) begin
            r = int'($urandom % 4);
            a_btn = (r == 0) ? 4'd0 : (r == 1) ? arrow : 4'($urandom);
         end
         if (($urandom % 3) == 0) begin
            r = int'($urandom % 4);
            b_btn = (r == 0) ? 4'd0 : (r == 1) ? arrow : 4'($urandom);
         end
         tick(1);
      end
      start = 1'b0; reset = 1'b0; a_btn = 4'd0; b_btn = 4'd0;
      tick(40);

      // saturation: A hits all 256 steps, B never presses
      hits2 = 0; amiss2 = 0; bhits2 = 0; bmiss2 = 0; fin2 = 1'b0;
      start2 = 1'b1; tick(1); start2 = 1'b0;
      for (int i = 0; i < 1100 && !fin2; i++) begin
         a2_btn = arrow2;
         tick(1);
         if (a2_hit) begin
            hits2++;
            if (hits2 == 256) chk("sat_score_on_hit", a2_score, 255);
         end
         if (a2_miss) amiss2++;
         if (b2_hit) bhits2++;
         if (b2_miss) bmiss2++;
         if (done2) fin2 = 1'b1;
      end
      chk("sat_done_reached", fin2, 1);
      chk("sat_a_score", a2_score, 255);
      chk("sat_hit_count", hits2, 256);
      chk("sat_a_miss_count", amiss2, 0);
      chk("sat_b_miss_count", bmiss2, 256);
      chk("sat_b_hit_count", bhits2, 0);
      chk("sat_b_score", b2_score, 0);
      chk("sat_busy", busy2, 0);
      chk("sat_step", step2, 255);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/step_prompt_judge.md
# step_prompt_judge

Round sequencer and hit judge for the two-player dance game. It generates a pseudo-random one-hot arrow prompt per step and times each step with a show/gap schedule. It judges each player's debounced 4-bit button levels against the prompt inside a timing window, producing hit/miss pulses and saturating per-player scores. It sits downstream of the button debouncer and drives the arrow LEDs and the score display.

## Interface
- STEP_TICKS, 25_000_000: length of SHOW phase in clocks (0.5 s at 50 MHz); must be ≥ 1.
- WINDOW_TICKS, 12_500_000: judging window at start of SHOW, in clocks; 1 ≤ WINDOW_TICKS ≤ STEP_TICKS.
- GAP_TICKS, 5_000_000: blank phase between steps, in clocks; must be ≥ 1.
- NUM_STEPS, 32: steps per round; 1..256.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a round from IDLE or DONE.
- a_btn  in  4  player A debounced button levels.
- b_btn  in  4  player B debounced button levels.
- arrow  out  4  current prompt, one-hot during SHOW, 0 otherwise.
- busy  out  1  high in SHOW or GAP.
- done  out  1  high in DONE.
- step_idx  out  8  index of current step, 0..NUM_STEPS-1.
- a_hit, b_hit  out  1  one-cycle hit pulse per player.
- a_miss, b_miss  out  1  one-cycle miss pulse per player.
- a_score, b_score  out  8  hits this round, saturating at 255.

## Operation
- States: IDLE, SHOW, GAP, DONE. Reset → IDLE. All outputs registered. Reset value of every output is 0. LFSR loads LFSR_SEED. Edge registers clear to 0.
- IDLE/DONE + start:
  - Clear scores and step_idx.
  - Advance LFSR once and set arrow = 1 << lfsr[1:0] from the advanced value.
  - Clear timer and both judged flags, then enter SHOW.
- start in SHOW/GAP is ignored.
- SHOW:
  - Timer counts 0..STEP_TICKS-1. The window is open while timer < WINDOW_TICKS.
  - Per player, press edge = btn & ~btn_prev is nonzero. btn_prev updates every cycle in every state.
  - Edge in window with judged=0: hit if btn == arrow exactly, else miss. Chords and wrong arrows are misses.
  - A judgement sets judged=1. Further edges this step are ignored, as are edges outside the window.
  - Hit increments score unless score == 255.
  - At timer == STEP_TICKS-1: each player with judged=0 gets a miss pulse, unless that player's press is judged in that same cycle, in which case the press judgement takes precedence.
  - Then arrow=0, timer=0, and the block enters GAP.
- GAP:
  - arrow=0, timer counts 0..GAP_TICKS-1. Edges are not judged.
  - At the end of GAP, if step_idx == NUM_STEPS-1, go to DONE.
  - Otherwise increment step_idx, advance the LFSR, load the new arrow, clear the judged flags, and enter SHOW.
- DONE: arrow=0, done=1; scores and step_idx hold until start or reset.
- LFSR: 16-bit Galois, right shift, XOR mask 16'hB400 when lsb=1. It advances only at step load and is not reseeded by start, so successive rounds differ.
- Players are fully independent; simultaneous events on A and B are both processed in the same cycle.
- Reset mid-round: returns to IDLE immediately, all outputs 0, LFSR reseeded.

## Timing
- start sampled at cycle t → arrow valid, busy=1, step_idx=0 at t+1. Timer is 0 at t+1.
- SHOW lasts exactly STEP_TICKS cycles and GAP exactly GAP_TICKS cycles.
- One step period is STEP_TICKS+GAP_TICKS. The round lasts NUM_STEPS × (STEP_TICKS+GAP_TICKS) cycles from t+1 to the DONE entry.
- An edge at cycle e in the window → hit/miss pulse at e+1, with score updated at e+1.
- Timeout miss is asserted in the first GAP cycle, coincident with arrow going to 0.
- done rises in the cycle after the last GAP cycle; busy falls the same cycle.
- Pulses are exactly one cycle; a player never receives more than one judgement pulse per step.

## Test plan
Parameters for all tests: STEP_TICKS=8, WINDOW_TICKS=4, GAP_TICKS=2, NUM_STEPS=3, default seed.
- Reset, then start → arrow = 1 << lfsr[1:0] of advanced seed at t+1, busy=1. After 30 cycles, done=1, arrow=0, all three steps observed.
- A presses exactly arrow at SHOW timer=2 → a_hit at next cycle, a_score=1. A second press in the same step gives no pulse.
- B presses a wrong button, or a chord of arrow plus another bit, at timer=1 → b_miss pulse, b_score unchanged. No timeout miss at the end of the step.
- Nobody presses in a step → a_miss and b_miss both pulse in the first GAP cycle. A press at timer=5 (window closed) → no pulse, then a timeout miss.
- Button held across the step boundary produces no new edge → timeout miss. Simultaneous A hit and B miss in the same cycle → both pulses in the same cycle.
- Reset asserted mid-SHOW → next cycle all outputs 0, state IDLE. Start again yields the same first arrow as after power-up reset. Force score=255, then a hit → score stays 255 while a_hit still pulses.
